// File: rtl/flock_pkg.sv
// rtl/flock_pkg.sv - shared types, constants and saturating helpers for the frequency-lock controller
package flock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SWEEP  = 2'd1,
    ST_TRACK  = 2'd2,
    ST_LOCKED = 2'd3
  } flock_state_t;

  localparam int ERR_W   = 9;
  localparam int MID_W   = 18;
  localparam int INTEG_W = 20;
  localparam int CNT_W   = 4;
  localparam int KP_SH   = 2;
  localparam int KI_SH   = 4;

  localparam logic [15:0] F_MIN      = 16'd2000;
  localparam logic [15:0] F_MAX      = 16'd2400;
  localparam logic [15:0] F_START    = 16'd2200;
  localparam logic [15:0] SWEEP_STEP = 16'd4;

  localparam logic [ERR_W-1:0] CAPTURE_TH = 9'd16;
  localparam logic [ERR_W-1:0] LOCK_TH    = 9'd4;
  localparam logic [CNT_W-1:0] LOCK_CNT   = 4'd8;
  localparam logic [CNT_W-1:0] UNLOCK_CNT = 4'd4;

  localparam logic signed [MID_W-1:0] F_MIN_S = {2'b00, F_MIN};
  localparam logic signed [MID_W-1:0] F_MAX_S = {2'b00, F_MAX};

  localparam logic signed [INTEG_W:0] INTEG_MAX = {2'b00, {(INTEG_W-1){1'b1}}};
  localparam logic signed [INTEG_W:0] INTEG_MIN = {2'b11, {(INTEG_W-1){1'b0}}};

  // Integrator sum carries one guard bit; fold it back into INTEG_W bits.
  function automatic logic signed [INTEG_W-1:0] sat_integ(input logic signed [INTEG_W:0] v);
    if (v > INTEG_MAX)
      return INTEG_MAX[INTEG_W-1:0];
    else if (v < INTEG_MIN)
      return INTEG_MIN[INTEG_W-1:0];
    else
      return v[INTEG_W-1:0];
  endfunction

  function automatic logic [15:0] clamp_freq(input logic signed [MID_W-1:0] raw);
    if (raw > F_MAX_S)
      return F_MAX;
    else if (raw < F_MIN_S)
      return F_MIN;
    else
      return raw[15:0];
  endfunction

  function automatic logic [ERR_W-1:0] abs_err(input logic signed [ERR_W-1:0] e);
    return e[ERR_W-1] ? -e : e;
  endfunction

endpackage

// File: rtl/freq_lock_ctrl_if.sv
// rtl/freq_lock_ctrl_if.sv - frequency word and lock status bundle driven by the controller
interface freq_lock_ctrl_if;
  logic [15:0] freq_word;
  logic        freq_valid;
  logic        locked;
  logic [1:0]  state;
  logic        sweep_wrap;

  modport master (output freq_word, freq_valid, locked, state, sweep_wrap);
  modport slave  (input  freq_word, freq_valid, locked, state, sweep_wrap);
endinterface

// File: rtl/flock_pi.sv
// rtl/flock_pi.sv - combinational PI step: saturated integrator, proportional term, clamped frequency
module flock_pi
  import flock_pkg::*;
(
  input  logic signed [ERR_W-1:0]   err,
  input  logic signed [INTEG_W-1:0] integ,
  input  logic        [15:0]        base,
  output logic signed [INTEG_W-1:0] integ_new,
  output logic        [15:0]        freq_word,
  output logic                      clamp_hi,
  output logic                      clamp_lo
);

  logic signed [INTEG_W:0]   integ_sum;
  logic signed [INTEG_W-1:0] i_shift;
  logic signed [MID_W-1:0]   p_term;
  logic signed [MID_W-1:0]   i_term;
  logic signed [MID_W-1:0]   base_s;
  logic signed [MID_W-1:0]   raw;

  assign integ_sum = {integ[INTEG_W-1], integ} + {{(INTEG_W+1-ERR_W){err[ERR_W-1]}}, err};
  assign integ_new = sat_integ(integ_sum);

  // i_shift is bounded to 16 significant bits, so the 18-bit slice is lossless.
  assign i_shift = integ_new >>> KI_SH;
  assign i_term  = i_shift[MID_W-1:0];
  assign p_term  = {{(MID_W-ERR_W){err[ERR_W-1]}}, err} <<< KP_SH;
  assign base_s  = {2'b00, base};
  assign raw     = base_s + p_term + i_term;

  assign clamp_hi  = raw > F_MAX_S;
  assign clamp_lo  = raw < F_MIN_S;
  assign freq_word = clamp_freq(raw);

endmodule

// File: rtl/freq_lock_ctrl.sv
// rtl/freq_lock_ctrl.sv - PI frequency-lock FSM with lock detection; FLOCK_SWEEP_EN adds the capture sweep
module freq_lock_ctrl
  import flock_pkg::*;
(
  input  logic              clk325kHz_d2,
  input  logic              rst_n,
  input  logic              pulse20kHz_d,
  input  logic              enable,
  input  logic signed [7:0] theta_f,
  input  logic signed [7:0] theta_ref,
  freq_lock_ctrl_if.master  fo
);

  flock_state_t state_q, state_d;
  logic                      pulse_q, upd_q, evt_q;
  logic signed [ERR_W-1:0]   err_now, err_q;
  logic [15:0]               freq_q, freq_d, base_q, base_d;
  logic signed [INTEG_W-1:0] integ_q, integ_d, pi_integ;
  logic [CNT_W-1:0]          lock_cnt_q, lock_cnt_d, unlock_cnt_q, unlock_cnt_d;
  logic                      locked_q, locked_d, valid_q, valid_d;
  logic [15:0]               pi_freq, sweep_next;
  logic                      pi_hi, pi_lo, in_lock, hold_integ;
`ifdef FLOCK_SWEEP_EN
  logic                      wrap_q, wrap_d;
`endif

  assign err_now = {theta_f[7], theta_f} - {theta_ref[7], theta_ref};

  flock_pi u_pi (
    .err       (err_q),
    .integ     (integ_q),
    .base      (base_q),
    .integ_new (pi_integ),
    .freq_word (pi_freq),
    .clamp_hi  (pi_hi),
    .clamp_lo  (pi_lo)
  );

  assign in_lock    = abs_err(err_q) <= LOCK_TH;
  assign hold_integ = (pi_hi && !err_q[ERR_W-1] && (err_q != '0)) || (pi_lo && err_q[ERR_W-1]);
  assign sweep_next = freq_q + SWEEP_STEP;

  always_ff @(posedge clk325kHz_d2 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pulse_q      <= 1'b0;
      upd_q        <= 1'b0;
      evt_q        <= 1'b0;
      err_q        <= '0;
      freq_q       <= F_START;
      base_q       <= F_START;
      integ_q      <= '0;
      lock_cnt_q   <= '0;
      unlock_cnt_q <= '0;
      locked_q     <= 1'b0;
      valid_q      <= 1'b0;
`ifdef FLOCK_SWEEP_EN
      wrap_q       <= 1'b0;
`endif
    end else begin
      pulse_q      <= pulse20kHz_d;
      upd_q        <= pulse20kHz_d & ~pulse_q;
      evt_q        <= upd_q & enable;
      if (upd_q)
        err_q      <= err_now;
      state_q      <= state_d;
      freq_q       <= freq_d;
      base_q       <= base_d;
      integ_q      <= integ_d;
      lock_cnt_q   <= lock_cnt_d;
      unlock_cnt_q <= unlock_cnt_d;
      locked_q     <= locked_d;
      valid_q      <= valid_d;
`ifdef FLOCK_SWEEP_EN
      wrap_q       <= wrap_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    freq_d       = freq_q;
    base_d       = base_q;
    integ_d      = integ_q;
    lock_cnt_d   = lock_cnt_q;
    unlock_cnt_d = unlock_cnt_q;
    locked_d     = locked_q;
    valid_d      = 1'b0;
`ifdef FLOCK_SWEEP_EN
    wrap_d       = 1'b0;
`endif
    // Dropping enable overrides any update in flight.
    if (!enable) begin
      state_d      = ST_IDLE;
      freq_d       = F_START;
      base_d       = F_START;
      integ_d      = '0;
      lock_cnt_d   = '0;
      unlock_cnt_d = '0;
      locked_d     = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
`ifdef FLOCK_SWEEP_EN
          state_d = ST_SWEEP;
          freq_d  = F_MIN;
`else
          state_d = ST_TRACK;
          base_d  = F_START;
          freq_d  = F_START;
`endif
        end
`ifdef FLOCK_SWEEP_EN
        ST_SWEEP: begin
          if (evt_q) begin
            valid_d = 1'b1;
            if (abs_err(err_q) <= CAPTURE_TH) begin
              state_d      = ST_TRACK;
              base_d       = freq_q;
              integ_d      = '0;
              lock_cnt_d   = '0;
              unlock_cnt_d = '0;
            end else if (sweep_next > F_MAX) begin
              freq_d = F_MIN;
              wrap_d = 1'b1;
            end else begin
              freq_d = sweep_next;
            end
          end
        end
`endif
        ST_TRACK, ST_LOCKED: begin
          if (evt_q) begin
            valid_d = 1'b1;
            freq_d  = pi_freq;
            if (!hold_integ)
              integ_d = pi_integ;
            if (state_q == ST_TRACK) begin
              if (!in_lock) begin
                lock_cnt_d = '0;
              end else if (lock_cnt_q + 4'd1 == LOCK_CNT) begin
                state_d      = ST_LOCKED;
                locked_d     = 1'b1;
                lock_cnt_d   = '0;
                unlock_cnt_d = '0;
              end else begin
                lock_cnt_d = lock_cnt_q + 4'd1;
              end
            end else begin
              if (in_lock) begin
                unlock_cnt_d = '0;
              end else if (unlock_cnt_q + 4'd1 == UNLOCK_CNT) begin
                state_d      = ST_TRACK;
                locked_d     = 1'b0;
                lock_cnt_d   = '0;
                unlock_cnt_d = '0;
              end else begin
                unlock_cnt_d = unlock_cnt_q + 4'd1;
              end
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign fo.freq_word  = freq_q;
  assign fo.freq_valid = valid_q;
  assign fo.locked     = locked_q;
  assign fo.state      = state_q;
`ifdef FLOCK_SWEEP_EN
  assign fo.sweep_wrap = wrap_q;
`else
  assign fo.sweep_wrap = 1'b0;
`endif

endmodule
